// File: rtl/subword_store_pkg.sv
// Shared types for the sub-word store controller: store-size opcodes and FSM states.
package subword_store_pkg;

  typedef enum logic [1:0] {
    OP_SW  = 2'b00,
    OP_SH  = 2'b01,
    OP_SB  = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WAIT  = 2'b10,
    ST_WRITE = 2'b11
  } state_e;

endpackage

// File: rtl/store_merge.sv
// Combinational lane merge: splices right-aligned store data into the old memory word.
import subword_store_pkg::*;

module store_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [1:0]  addr_lo,
  input  op_e         op,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    case (op)
      OP_SB: begin
        case (addr_lo)
          2'b00:   merged[7:0]   = new_data[7:0];
          2'b01:   merged[15:8]  = new_data[7:0];
          2'b10:   merged[23:16] = new_data[7:0];
          default: merged[31:24] = new_data[7:0];
        endcase
      end
      // Halfword lane comes from addr[1] alone; addr[0] is ignored here.
      OP_SH: begin
        if (addr_lo[1]) merged[31:16] = new_data[15:0];
        else            merged[15:0]  = new_data[15:0];
      end
      default: merged = new_data;
    endcase
  end

endmodule

// File: rtl/subword_store_ctrl.sv
// Sub-word store controller: read-modify-write for SH/SB, direct write for SW.
// Optional macro SUBWORD_STORE_ALIGN_CHECK_EN rejects misaligned SW/SH requests.
import subword_store_pkg::*;

module subword_store_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              done,
  output logic              err
);

  // state    | meaning
  // ST_IDLE  | ready for a request
  // ST_READ  | read strobe for the containing word
  // ST_WAIT  | read data returns, merged word registered
  // ST_WRITE | write strobe and done pulse

  state_e            state, state_next;
  op_e               op_in, op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       merged, merged_q;
  logic              reject, accept;

  assign op_in  = op_e'(req_op);
  assign accept = (state == ST_IDLE) && req_valid;

  always_comb begin
    reject = (op_in == OP_RSV);
`ifdef SUBWORD_STORE_ALIGN_CHECK_EN
    if (op_in == OP_SW && req_addr[1:0] != 2'b00) reject = 1'b1;
    if (op_in == OP_SH && req_addr[0])            reject = 1'b1;
`endif
  end

  store_merge u_merge (
    .old_word (mem_rdata),
    .new_data (wdata_q),
    .addr_lo  (addr_q[1:0]),
    .op       (op_q),
    .merged   (merged)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_q     <= OP_SW;
      addr_q   <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_next;
      err   <= accept && reject;
      if (accept) begin
        op_q    <= op_in;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == ST_WAIT) merged_q <= merged;
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !reject)
          state_next = (op_in == OP_SW) ? ST_WRITE : ST_READ;
      end
      ST_READ: begin
        mem_en     = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: state_next = ST_WRITE;
      ST_WRITE: begin
        mem_en     = 1'b1;
        mem_we     = 1'b1;
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata = (op_q == OP_SW) ? wdata_q : merged_q;

endmodule

// File: tb/tb_subword_store_ctrl.sv
// Directed bench for subword_store_ctrl; inputs change and outputs are sampled on the falling edge.
module tb_subword_store_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cyc[3];

  subword_store_ctrl #(.ADDR_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with the DUT idle; returns at the falling edge of the next idle cycle.
  task automatic sw_store(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] exp_addr);
    chk({tag, " ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = 2'b00; req_addr = addr; req_wdata = data;
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, " en"},    {31'b0, mem_en}, 32'd1);
    chk({tag, " we"},    {31'b0, mem_we}, 32'd1);
    chk({tag, " addr"},  mem_addr, exp_addr);
    chk({tag, " wdata"}, mem_wdata, data);
    chk({tag, " done"},  {31'b0, done}, 32'd1);
    @(negedge clk);
    chk({tag, " idle en"}, {31'b0, mem_en}, 32'd0);
  endtask

  task automatic sub_store(input string tag, input logic [1:0] op, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] rd,
                           input logic [31:0] exp_word, output int wcyc);
    chk({tag, " ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = data;
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, " rd en"},   {31'b0, mem_en}, 32'd1);
    chk({tag, " rd we"},   {31'b0, mem_we}, 32'd0);
    chk({tag, " rd addr"}, mem_addr, {addr[31:2], 2'b00});
    chk({tag, " rd done"}, {31'b0, done}, 32'd0);
    mem_rdata = rd;
    @(negedge clk);
    chk({tag, " wait en"}, {31'b0, mem_en}, 32'd0);
    @(negedge clk);
    mem_rdata = 32'hFFFF_FFFF;
    wcyc = cyc;
    chk({tag, " wr en"},    {31'b0, mem_en}, 32'd1);
    chk({tag, " wr we"},    {31'b0, mem_we}, 32'd1);
    chk({tag, " wr addr"},  mem_addr, {addr[31:2], 2'b00});
    chk({tag, " wr wdata"}, mem_wdata, exp_word);
    chk({tag, " wr done"},  {31'b0, done}, 32'd1);
    @(negedge clk);
    chk({tag, " idle ready"}, {31'b0, req_ready}, 32'd1);
  endtask

  task automatic rejected(input string tag, input logic [1:0] op, input logic [31:0] addr);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = 32'h1234_5678;
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, " err"},   {31'b0, err}, 32'd1);
    chk({tag, " en"},    {31'b0, mem_en}, 32'd0);
    chk({tag, " ready"}, {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    chk({tag, " err drop"}, {31'b0, err}, 32'd0);
    chk({tag, " en2"},      {31'b0, mem_en}, 32'd0);
  endtask

  initial begin
    int w;
    reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_addr = '0; req_wdata = '0;
    mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("rst en",    {31'b0, mem_en}, 32'd0);
    chk("rst we",    {31'b0, mem_we}, 32'd0);
    chk("rst done",  {31'b0, done}, 32'd0);
    chk("rst err",   {31'b0, err}, 32'd0);
    chk("rst addr",  mem_addr, 32'd0);
    chk("rst wdata", mem_wdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst ready", {31'b0, req_ready}, 32'd1);

    sw_store("sw100", 32'h100, 32'hDEAD_BEEF, 32'h100);
    sub_store("sb203", 2'b10, 32'h203, 32'h0000_00AA, 32'h1122_3344, 32'hAA22_3344, w);
    sub_store("sh302", 2'b01, 32'h302, 32'h0000_BEEF, 32'h1122_3344, 32'hBEEF_3344, w);
    sub_store("sh300", 2'b01, 32'h300, 32'h0000_BEEF, 32'h1122_3344, 32'h1122_BEEF, w);
`ifdef SUBWORD_STORE_ALIGN_CHECK_EN
    rejected("sh301", 2'b01, 32'h301);
    rejected("sw103", 2'b00, 32'h103);
`else
    sub_store("sh301", 2'b01, 32'h301, 32'h0000_BEEF, 32'h1122_3344, 32'h1122_BEEF, w);
    sub_store("sh303", 2'b01, 32'h303, 32'h0000_BEEF, 32'h1122_3344, 32'hBEEF_3344, w);
    sw_store("sw103", 32'h103, 32'hCAFE_F00D, 32'h100);
`endif

    // Reset while an SB sits in WAIT: nothing may be written.
    req_valid = 1'b1; req_op = 2'b10; req_addr = 32'h50; req_wdata = 32'h99;
    @(negedge clk);
    req_valid = 1'b0; mem_rdata = 32'h1122_3344;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid rst en",    {31'b0, mem_en}, 32'd0);
    chk("mid rst done",  {31'b0, done}, 32'd0);
    chk("mid rst addr",  mem_addr, 32'd0);
    chk("mid rst wdata", mem_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post rst en",   {31'b0, mem_en}, 32'd0);
    chk("post rst done", {31'b0, done}, 32'd0);
    sw_store("sw after rst", 32'h600, 32'h0BAD_CAFE, 32'h600);

    rejected("rsv", 2'b11, 32'h700);

    sub_store("b2b0", 2'b10, 32'h400, 32'h55, 32'h1122_3344, 32'h1122_3355, wr_cyc[0]);
    sub_store("b2b1", 2'b10, 32'h401, 32'h66, 32'h1122_3344, 32'h1122_6644, wr_cyc[1]);
    sub_store("b2b2", 2'b10, 32'h402, 32'h77, 32'h1122_3344, 32'h1177_3344, wr_cyc[2]);
    chk("b2b gap01", wr_cyc[1] - wr_cyc[0], 32'd4);
    chk("b2b gap12", wr_cyc[2] - wr_cyc[1], 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/subword_store_ctrl.md
SUBWORD_STORE_CTRL -- requirements
Module: subword_store_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter ADDR_W, default 32: byte-address width.
REQ-003 Port clk  in  1  rising-edge clock.
REQ-004 Port reset  in  1  async active-high reset.
REQ-005 Port req_valid  in  1  store request present.
REQ-006 Port req_ready  out  1  controller accepts request this cycle.
REQ-007 Port req_op  in  2  store size: 00 SW, 01 SH, 10 SB, 11 reserved.
REQ-008 Port req_addr  in  ADDR_W  byte address.
REQ-009 Port req_wdata  in  32  store data, right-aligned (SB uses [7:0], SH uses [15:0]).
REQ-010 Port mem_en  out  1  memory access strobe.
REQ-011 Port mem_we  out  1  1 = write, 0 = read; valid only with mem_en.
REQ-012 Port mem_addr  out  ADDR_W  word address, bits [1:0] always 00.
REQ-013 Port mem_wdata  out  32  word written to memory.
REQ-014 Port mem_rdata  in  32  read data, valid the cycle after a read strobe.
REQ-015 Port done  out  1  one-cycle pulse in the cycle of the final write.
REQ-016 Port err  out  1  one-cycle pulse on rejected request.

Function
REQ-017 States SHALL be IDLE, READ, WAIT, WRITE; req_ready SHALL be 1 only in IDLE.
REQ-018 In IDLE, req_valid=1 SHALL capture op/addr/wdata. SW goes to WRITE; SH/SB go to READ; reserved op pulses err next cycle, stays IDLE, no memory access.
REQ-019 READ SHALL drive mem_en=1, mem_we=0, mem_addr={addr[ADDR_W-1:2],00}, then go to WAIT.
REQ-020 WAIT SHALL register the merged word from mem_rdata, then go to WRITE.
REQ-021 SB merge: byte lane addr[1:0] (00 -> [7:0], 01 -> [15:8], 10 -> [23:16], 11 -> [31:24]) replaced by wdata[7:0]; other lanes from mem_rdata.
REQ-022 SH merge: addr[1]=0 replaces [15:0], addr[1]=1 replaces [31:16], with wdata[15:0]; other half from mem_rdata.
REQ-023 WRITE SHALL drive mem_en=1, mem_we=1, word address, mem_wdata (SW: captured wdata; SH/SB: merged word), assert done, and return to IDLE.
REQ-024 Latency from acceptance cycle T: SW done at T+1; SH/SB read at T+1, write and done at T+3.
REQ-025 Back-to-back: a request may be accepted in the IDLE cycle following WRITE; no request is accepted during WRITE.
REQ-026 Outside READ/WRITE, mem_en SHALL be 0; mem_wdata and mem_addr are don't-care when mem_en=0.

Reset
REQ-027 Reset SHALL force state IDLE and mem_en=0, mem_we=0, done=0, err=0, mem_addr=0, mem_wdata=0, with req_ready=1 after release.
REQ-028 Reset mid-operation SHALL abandon the store with no write strobe and no done.

Configuration
REQ-029 Macro SUBWORD_STORE_ALIGN_CHECK_EN defined: SW with addr[1:0]!=00 or SH with addr[0]=1 SHALL be rejected like a reserved op (err pulse, no access).
REQ-030 Macro undefined: SW SHALL ignore addr[1:0]; SH SHALL use addr[1] only, so SH at 01 writes [15:0] and SH at 11 writes [31:16]; err is driven only for reserved op.

Structure
REQ-031 Package subword_store_pkg SHALL hold the op enum (OP_SW, OP_SH, OP_SB, OP_RSV) and state enum.
REQ-032 Lane merge SHALL be a combinational sub-module store_merge (inputs: old word, new data, addr[1:0], op; output: merged word).

Verification
REQ-033 SW addr 0x100, wdata 0xDEADBEEF -> T+1: mem_we=1, addr 0x100, mem_wdata 0xDEADBEEF, done=1.
REQ-034 SB addr 0x203, wdata 0x000000AA, mem_rdata 0x11223344 -> read 0x200 at T+1, write 0xAA223344 with done at T+3.
REQ-035 SH addr 0x302, wdata 0x0000BEEF, mem_rdata 0x11223344 -> write 0xBEEF3344; SH addr 0x300 -> 0x1122BEEF.
REQ-036 SH addr 0x301 -> with the macro: err pulse and no mem_en; without it: write 0x1122BEEF.
REQ-037 Reset asserted during WAIT of an SB -> no write strobe, outputs at reset values, and the next SW completes normally.
REQ-038 Reserved op 11 -> err pulse and no mem_en; then three back-to-back SB requests -> three writes, each 4 cycles apart.
